// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register bank: address map,
// commit states and sizing helpers.
package spi_pkg;

    typedef enum logic {
        CLEAN = 1'b0,
        DIRTY = 1'b1
    } commit_state_t;

    localparam int RO_BASE = 0;

    function automatic int rw_base(input int num_ro);
        return RO_BASE + num_ro;
    endfunction

    function automatic int errcnt_addr(input int depth);
        return (1 << depth) - 1;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/spi_register_bank_if.sv
// Host-side register access bus between the SPI slave
// and the register bank.
interface spi_register_bank_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    logic             START;
    logic             WREN;
    logic [DEPTH-1:0] ADDRESS;
    logic [WIDTH-1:0] WRITE_DATA;
    logic [WIDTH-1:0] READ_DATA;

    modport master (
        output START, WREN, ADDRESS, WRITE_DATA,
        input  READ_DATA
    );

    modport slave (
        input  START, WREN, ADDRESS, WRITE_DATA,
        output READ_DATA
    );
endinterface

// File: rtl/spi_commit_ctrl.sv
// Decides when dirty control shadows are pushed to the
// active registers: on START or after an idle timeout.
module spi_commit_ctrl
    import spi_pkg::*;
#(
    parameter int COMMIT_IDLE = 1024
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic start,
    input  logic rw_write,
    input  logic any_write,
    output logic commit,
    output logic dirty
);
    localparam int CW = clog2(COMMIT_IDLE + 1);
    localparam logic [CW-1:0] IDLE_LAST = CW'(COMMIT_IDLE - 1);

    commit_state_t state, state_nxt;
    logic [CW-1:0] idle, idle_nxt;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state <= CLEAN;
            idle  <= '0;
        end else begin
            state <= state_nxt;
            idle  <= idle_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idle_nxt  = idle;
        commit    = 1'b0;
        unique case (state)
            CLEAN: begin
                if (rw_write) begin
                    state_nxt = DIRTY;
                    idle_nxt  = '0;
                end
            end
            DIRTY: begin
                // a write landing with the commit starts a new dirty window
                if (start || (!any_write && idle == IDLE_LAST)) begin
                    commit    = 1'b1;
                    state_nxt = rw_write ? DIRTY : CLEAN;
                    idle_nxt  = '0;
                end else if (any_write) begin
                    idle_nxt = '0;
                end else begin
                    idle_nxt = idle + CW'(1);
                end
            end
            default: begin
                state_nxt = CLEAN;
                idle_nxt  = '0;
            end
        endcase
    end

    assign dirty = (state == DIRTY);
endmodule

// File: rtl/spi_register_bank.sv
// Register bank behind the SPI slave: status snapshot, shadowed
// control registers with atomic commit, sticky error counter.
module spi_register_bank
    import spi_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int NUM_RO      = 4,
    parameter int NUM_RW      = 8,
    parameter int COMMIT_IDLE = 1024,
    parameter logic [NUM_RW*WIDTH-1:0] CTRL_RESET = '0
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    spi_register_bank_if.slave       bus,
    input  logic [NUM_RO*WIDTH-1:0]  STATUS_IN,
    output logic [NUM_RW*WIDTH-1:0]  CTRL_OUT,
    output logic                     COMMIT,
    output logic                     ERROR
);
    localparam int RW_BASE  = rw_base(NUM_RO);
    localparam int ERR_ADDR = errcnt_addr(DEPTH);

    if (NUM_RO + NUM_RW + 1 > (1 << DEPTH)) begin : g_map_check
        $error("register map does not fit the address space");
    end

    logic [WIDTH-1:0] snap   [NUM_RO];
    logic [WIDTH-1:0] shadow [NUM_RW];
    logic [WIDTH-1:0] active [NUM_RW];
    logic [WIDTH-1:0] errcnt, errcnt_nxt, rd_nxt;
    logic             rw_hit, err_hit, commit, dirty;

    always_comb begin
        rw_hit  = 1'b0;
        err_hit = (bus.ADDRESS == DEPTH'(ERR_ADDR));
        rd_nxt  = '0;
        for (int k = 0; k < NUM_RO; k++)
            if (bus.ADDRESS == DEPTH'(RO_BASE + k)) rd_nxt = snap[k];
        for (int k = 0; k < NUM_RW; k++)
            if (bus.ADDRESS == DEPTH'(RW_BASE + k)) begin
                rw_hit = 1'b1;
                rd_nxt = shadow[k];
            end
        if (err_hit) rd_nxt = errcnt;
    end

    always_comb begin
        errcnt_nxt = errcnt;
        if (bus.WREN) begin
            if (err_hit)
                errcnt_nxt = '0;
            else if (!rw_hit && errcnt != '1)
                errcnt_nxt = errcnt + WIDTH'(1);
        end
    end

    spi_commit_ctrl #(
        .COMMIT_IDLE (COMMIT_IDLE)
    ) u_commit (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .start     (bus.START),
        .rw_write  (bus.WREN && rw_hit),
        .any_write (bus.WREN),
        .commit    (commit),
        .dirty     (dirty)
    );

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            for (int k = 0; k < NUM_RO; k++) snap[k] <= '0;
            for (int k = 0; k < NUM_RW; k++) begin
                shadow[k] <= CTRL_RESET[k*WIDTH +: WIDTH];
                active[k] <= CTRL_RESET[k*WIDTH +: WIDTH];
            end
            errcnt        <= '0;
            ERROR         <= 1'b0;
            COMMIT        <= 1'b0;
            bus.READ_DATA <= '0;
        end else begin
            if (bus.START)
                for (int k = 0; k < NUM_RO; k++)
                    snap[k] <= STATUS_IN[k*WIDTH +: WIDTH];
            // active takes the shadow as it was before this edge's write
            if (commit && dirty)
                for (int k = 0; k < NUM_RW; k++) active[k] <= shadow[k];
            if (bus.WREN)
                for (int k = 0; k < NUM_RW; k++)
                    if (bus.ADDRESS == DEPTH'(RW_BASE + k))
                        shadow[k] <= bus.WRITE_DATA;
            errcnt        <= errcnt_nxt;
            ERROR         <= (errcnt_nxt != '0);
            COMMIT        <= commit && dirty;
            bus.READ_DATA <= rd_nxt;
        end
    end

    always_comb begin
        CTRL_OUT = '0;
        for (int k = 0; k < NUM_RW; k++)
            CTRL_OUT[k*WIDTH +: WIDTH] = active[k];
    end
endmodule

// File: tb/tb_spi_register_bank.sv
// Randomized and directed checks of spi_register_bank against
// a behavioural model of the register map and commit rules.
module tb_spi_register_bank;
    localparam int IDLE = 1024;
    localparam logic [63:0] CR = 64'h8877_6655_4433_2211;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [31:0] STATUS_IN;
    logic [63:0] CTRL_OUT;
    logic        COMMIT, ERROR;

    spi_register_bank_if #(.WIDTH(8), .DEPTH(4)) bus ();

    spi_register_bank #(
        .COMMIT_IDLE (IDLE),
        .CTRL_RESET  (CR)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .bus       (bus),
        .STATUS_IN (STATUS_IN),
        .CTRL_OUT  (CTRL_OUT),
        .COMMIT    (COMMIT),
        .ERROR     (ERROR)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;
    int n_commit = 0;

    logic [7:0] m_sh [8];
    logic [7:0] m_ac [8];
    logic [7:0] m_sn [4];
    int         m_err;
    bit         m_dirty;
    int         m_idle;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack_active();
        logic [63:0] v;
        for (int k = 0; k < 8; k++) v[k*8 +: 8] = m_ac[k];
        return v;
    endfunction

    task automatic cycle(input bit rn, input bit st, input bit we,
                         input logic [3:0] a, input logic [7:0] d);
        logic [7:0] rd;
        bit         cm, rw;
        int         ai;
        ai = int'(a);
        rw = (ai >= 4 && ai < 12);
        RESET_N        = rn;
        bus.START      = st;
        bus.WREN       = we;
        bus.ADDRESS    = a;
        bus.WRITE_DATA = d;
        @(posedge CLK);
        if (!rn) begin
            for (int k = 0; k < 8; k++) begin
                m_sh[k] = CR[k*8 +: 8];
                m_ac[k] = CR[k*8 +: 8];
            end
            for (int k = 0; k < 4; k++) m_sn[k] = 8'h00;
            m_err = 0; m_dirty = 0; m_idle = 0;
            rd = 8'h00; cm = 0;
        end else begin
            if (ai < 4)       rd = m_sn[ai];
            else if (rw)      rd = m_sh[ai-4];
            else if (ai == 15) rd = 8'(m_err);
            else              rd = 8'h00;
            cm = m_dirty && (st || (!we && m_idle == IDLE - 1));
            if (cm) for (int k = 0; k < 8; k++) m_ac[k] = m_sh[k];
            if (st) for (int k = 0; k < 4; k++)
                m_sn[k] = STATUS_IN[k*8 +: 8];
            if (we) begin
                if (rw) m_sh[ai-4] = d;
                else if (ai == 15) m_err = 0;
                else if (m_err < 255) m_err++;
            end
            if (cm) m_dirty = we && rw;
            else if (we && rw) m_dirty = 1;
            if (we || cm) m_idle = 0;
            else if (m_dirty) m_idle++;
        end
        #1;
        chk("rdata", 64'(bus.READ_DATA), 64'(rd));
        chk("commit", 64'(COMMIT), 64'(cm));
        chk("ctrl_out", CTRL_OUT, pack_active());
        chk("error", 64'(ERROR), 64'(m_err != 0));
        if (COMMIT) n_commit++;
    endtask

    initial begin
        RESET_N = 0; STATUS_IN = '0;
        bus.START = 0; bus.WREN = 0;
        bus.ADDRESS = '0; bus.WRITE_DATA = '0;
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        chk("rst_ctrl", CTRL_OUT, CR);

        // 1: full map readback after reset
        n_commit = 0;
        for (int a = 0; a < 16; a++) cycle(1, 0, 0, 4'(a), 0);
        cycle(1, 0, 0, 4'd4, 0);
        chk("rst_rw4", 64'(bus.READ_DATA), 64'h11);
        chk("rst_no_commit", 64'(n_commit), 0);

        // 2: snapshot is not live status
        STATUS_IN = 32'h0000_003C;
        cycle(1, 1, 0, 0, 0);
        STATUS_IN = 32'h0000_0055;
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        chk("snap0", 64'(bus.READ_DATA), 64'h3C);

        // 3: idle-timeout commit
        n_commit = 0;
        cycle(1, 0, 1, 4'd4, 8'hA7);
        cycle(1, 0, 0, 4'd4, 0);
        chk("rw4_read", 64'(bus.READ_DATA), 64'hA7);
        for (int i = 2; i < IDLE; i++) cycle(1, 0, 0, 4'd4, 0);
        chk("pre_idle_ctrl", 64'(CTRL_OUT[7:0]), 64'h11);
        cycle(1, 0, 0, 4'd4, 0);
        chk("idle_commit", 64'(COMMIT), 1);
        chk("idle_ctrl", 64'(CTRL_OUT[7:0]), 64'hA7);
        cycle(1, 0, 0, 4'd4, 0);
        chk("one_pulse", 64'(n_commit), 1);

        // 4: START commit coinciding with a write
        cycle(1, 0, 1, 4'd5, 8'h11);
        for (int i = 0; i < 10; i++) cycle(1, 0, 0, 4'd5, 0);
        cycle(1, 1, 1, 4'd5, 8'h22);
        chk("start_commit", 64'(COMMIT), 1);
        chk("start_byte1", 64'(CTRL_OUT[15:8]), 64'h11);
        cycle(1, 0, 0, 4'd5, 0);
        chk("shadow5", 64'(bus.READ_DATA), 64'h22);
        for (int i = 1; i < IDLE; i++) cycle(1, 0, 0, 4'd5, 0);
        chk("late_byte1", 64'(CTRL_OUT[15:8]), 64'h22);

        // 5: saturating error counter and clear
        for (int i = 0; i < 300; i++)
            cycle(1, 0, 1, 4'd1, 8'($urandom));
        cycle(1, 0, 0, 4'd15, 0);
        cycle(1, 0, 0, 4'd15, 0);
        chk("errcnt_sat", 64'(bus.READ_DATA), 64'hFF);
        chk("error_set", 64'(ERROR), 1);
        cycle(1, 0, 1, 4'd15, 8'h5A);
        chk("error_clr", 64'(ERROR), 0);
        cycle(1, 0, 0, 4'd15, 0);
        chk("errcnt_clr", 64'(bus.READ_DATA), 0);

        // 6: reset discards a pending shadow
        n_commit = 0;
        cycle(1, 0, 1, 4'd6, 8'h99);
        cycle(0, 0, 0, 4'd6, 0);
        chk("rst_pend_ctrl", CTRL_OUT, CR);
        cycle(1, 0, 0, 4'd6, 0);
        cycle(1, 0, 0, 4'd6, 0);
        chk("rst_pend_rd", 64'(bus.READ_DATA), 64'h33);
        chk("rst_pend_pulse", 64'(n_commit), 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            STATUS_IN = $urandom;
            cycle($urandom_range(0, 399) != 0,
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 2) == 0,
                  4'($urandom_range(0, 15)),
                  8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
